n64adv2_vdemux_gen: RTL and testbench



---
 rtl/n64adv2_vdemux_gen.sv | 186 ++++++++++++++++++
 tb/tb_n64adv2_vdemux_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/n64adv2_vdemux_gen.sv
// N64 serial video bus demultiplexer: sync/colour slot capture, bus phase lock and frame tracking.
// Optional horizontal pixel counter (hpixels_o) enabled by defining N64_VDEMUX_HCNT_EN.
module n64adv2_vdemux_gen #(
    parameter int color_width_i = 7,
    parameter int NCH           = 3,
    parameter int LOCK_GROUPS   = 16,
    parameter int PAL_THRESH    = 290,
    parameter int LCNT_W        = 10
) (
    input  logic                         N64_CLK_i,
    input  logic                         N64_VRST_i,
    input  logic                         nVDSYNC_i,
    input  logic [color_width_i-1:0]     VD_i,
    output logic [3:0]                   sync_o,
    output logic [NCH*color_width_i-1:0] pixel_o,
    output logic                         valid_o,
    output logic                         lock_o,
    output logic                         palmode_o,
    output logic                         interlaced_o,
    output logic [LCNT_W-1:0]            vlines_o
`ifdef N64_VDEMUX_HCNT_EN
    ,
    output logic [11:0]                  hpixels_o
`endif
);

    localparam int PH_W = $clog2(NCH + 1);
    localparam int GC_W = $clog2(LOCK_GROUPS + 1);
    localparam int PW   = NCH * color_width_i;
    localparam logic [PH_W-1:0] PH_MAX = PH_W'(NCH);
    localparam logic [GC_W-1:0] GC_MAX = GC_W'(LOCK_GROUPS);

    logic [PH_W-1:0]   ph_q, ph_d, ph_inc;
    logic [3:0]        sync_sh_q, sync_sh_d;
    logic              pend_q, pend_d;
    logic [GC_W-1:0]   gcnt_q, gcnt_d;
    logic              lock_q, lock_d;
    logic [3:0]        sync_q, sync_d;
    logic [PW-1:0]     pixel_q, pixel_d, slot_flat;
    logic              valid_q, valid_d;
    logic              hs_q, hs_d, vs_q, vs_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d, vlines_q, vlines_d, ldiff;
    logic              pal_q, pal_d, intl_q, intl_d;
    logic              adv, early, late, good, hs_fall, vs_fall;

    assign ph_inc = ph_q + PH_W'(1);
    assign adv    = nVDSYNC_i && (ph_q != PH_MAX);
    assign early  = !nVDSYNC_i && (ph_q != PH_MAX);
    assign good   = !nVDSYNC_i && (ph_q == PH_MAX);
    assign late   = nVDSYNC_i && (ph_q == PH_MAX);

    // Colour slot k is captured on the clock the phase counter steps to k; slot 1 lands in the MSBs.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_slot
        logic [color_width_i-1:0] slot_q, slot_d;
        always_comb slot_d = (adv && (ph_inc == PH_W'(gi + 1))) ? VD_i : slot_q;
        always_ff @(posedge N64_CLK_i or posedge N64_VRST_i) begin
            if (N64_VRST_i) slot_q <= '0;
            else            slot_q <= slot_d;
        end
        assign slot_flat[PW-1-gi*color_width_i -: color_width_i] = slot_q;
    end

    always_comb begin
        ph_d      = ph_q;
        sync_sh_d = sync_sh_q;
        pend_d    = 1'b0;
        gcnt_d    = gcnt_q;
        lock_d    = lock_q;
        if (!nVDSYNC_i) begin
            ph_d      = '0;
            sync_sh_d = VD_i[3:0];
        end else if (adv) begin
            ph_d   = ph_inc;
            pend_d = (ph_inc == PH_MAX);
        end
        if (early || late) begin
            gcnt_d = '0;
            lock_d = 1'b0;
        end else if (good) begin
            if (gcnt_q != GC_MAX) gcnt_d = gcnt_q + GC_W'(1);
            lock_d = (gcnt_d == GC_MAX);
        end
    end

    // Frame state is updated together with the output registers, from the group being published.
    assign hs_fall = pend_q && hs_q && !sync_sh_q[2];
    assign vs_fall = pend_q && vs_q && !sync_sh_q[3];
    assign ldiff   = (lcnt_q > vlines_q) ? (lcnt_q - vlines_q) : (vlines_q - lcnt_q);

    always_comb begin
        valid_d  = pend_q;
        sync_d   = pend_q ? sync_sh_q : sync_q;
        pixel_d  = pend_q ? slot_flat : pixel_q;
        hs_d     = pend_q ? sync_sh_q[2] : hs_q;
        vs_d     = pend_q ? sync_sh_q[3] : vs_q;
        lcnt_d   = lcnt_q;
        vlines_d = vlines_q;
        pal_d    = pal_q;
        intl_d   = intl_q;
        if (vs_fall) begin
            lcnt_d = '0;
            if (lock_q) begin
                vlines_d = lcnt_q;
                pal_d    = (lcnt_q >= LCNT_W'(PAL_THRESH));
                intl_d   = (ldiff == LCNT_W'(1));
            end
        end else if (hs_fall && (lcnt_q != '1)) begin
            lcnt_d = lcnt_q + LCNT_W'(1);
        end
    end

    always_ff @(posedge N64_CLK_i or posedge N64_VRST_i) begin
        if (N64_VRST_i) begin
            ph_q      <= '0;
            sync_sh_q <= '0;
            pend_q    <= 1'b0;
            gcnt_q    <= '0;
            lock_q    <= 1'b0;
            valid_q   <= 1'b0;
            sync_q    <= '0;
            pixel_q   <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            lcnt_q    <= '0;
            vlines_q  <= '0;
            pal_q     <= 1'b0;
            intl_q    <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            sync_sh_q <= sync_sh_d;
            pend_q    <= pend_d;
            gcnt_q    <= gcnt_d;
            lock_q    <= lock_d;
            valid_q   <= valid_d;
            sync_q    <= sync_d;
            pixel_q   <= pixel_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            lcnt_q    <= lcnt_d;
            vlines_q  <= vlines_d;
            pal_q     <= pal_d;
            intl_q    <= intl_d;
        end
    end

    assign sync_o       = sync_q;
    assign pixel_o      = pixel_q;
    assign valid_o      = valid_q;
    assign lock_o       = lock_q;
    assign palmode_o    = pal_q;
    assign interlaced_o = intl_q;
    assign vlines_o     = vlines_q;

`ifdef N64_VDEMUX_HCNT_EN
    // Counts published groups from one HS falling edge up to (not including) the next.
    logic [11:0] hcnt_q, hcnt_d, hpix_q, hpix_d;

    always_comb begin
        hcnt_d = hcnt_q;
        hpix_d = hpix_q;
        if (pend_q) begin
            if (hs_fall) begin
                hpix_d = hcnt_q;
                hcnt_d = 12'd1;
            end else if (hcnt_q != 12'hFFF) begin
                hcnt_d = hcnt_q + 12'd1;
            end
        end
    end

    always_ff @(posedge N64_CLK_i or posedge N64_VRST_i) begin
        if (N64_VRST_i) begin
            hcnt_q <= '0;
            hpix_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            hpix_q <= hpix_d;
        end
    end

    assign hpixels_o = hpix_q;
`else
    // Horizontal pixel counter not built.
`endif

endmodule

// File: tb/tb_n64adv2_vdemux_gen.sv
// Directed self-checking bench for n64adv2_vdemux_gen (NCH=3, 7-bit bus).
module tb_n64adv2_vdemux_gen;
    localparam int W = 7;
    localparam int NCH = 3;
    localparam int LCNT_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              nv  = 1'b1;
    logic [W-1:0]      vd  = '0;
    logic [3:0]        sync_o;
    logic [NCH*W-1:0]  pixel_o;
    logic              valid_o, lock_o, palmode_o, interlaced_o;
    logic [LCNT_W-1:0] vlines_o;
`ifdef N64_VDEMUX_HCNT_EN
    logic [11:0]       hpixels_o;
`endif

    n64adv2_vdemux_gen #(
        .color_width_i(W), .NCH(NCH), .LOCK_GROUPS(16), .PAL_THRESH(290), .LCNT_W(LCNT_W)
    ) dut (
        .N64_CLK_i   (clk),
        .N64_VRST_i  (rst),
        .nVDSYNC_i   (nv),
        .VD_i        (vd),
        .sync_o      (sync_o),
        .pixel_o     (pixel_o),
        .valid_o     (valid_o),
        .lock_o      (lock_o),
        .palmode_o   (palmode_o),
        .interlaced_o(interlaced_o),
        .vlines_o    (vlines_o)
`ifdef N64_VDEMUX_HCNT_EN
        ,
        .hpixels_o   (hpixels_o)
`endif
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    int vcnt = 0;
    int vsnap;
    logic [NCH*W-1:0] last_pix = '0;
    logic [3:0]       last_sync = '0;

    always @(posedge clk) begin
        #1;
        if (valid_o === 1'b1) begin
            vcnt++;
            last_pix  = pixel_o;
            last_sync = sync_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_group(input logic [3:0] s, input logic [W-1:0] r, input logic [W-1:0] g,
                              input logic [W-1:0] b);
        nv = 1'b0; vd = {3'b000, s}; @(negedge clk);
        nv = 1'b1; vd = r;           @(negedge clk);
        vd = g;                      @(negedge clk);
        vd = b;                      @(negedge clk);
    endtask

    // One VS falling edge followed by n HS falling edges.
    task automatic frame(input int n);
        send_group(4'hC, 7'h01, 7'h02, 7'h03);
        send_group(4'h4, 7'h01, 7'h02, 7'h03);
        repeat (n) begin
            send_group(4'h4, 7'h01, 7'h02, 7'h03);
            send_group(4'h0, 7'h01, 7'h02, 7'h03);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_sync", 32'(sync_o), 32'h0);
        check("rst_pixel", 32'(pixel_o), 32'h0);
        check("rst_lock", 32'(lock_o), 32'h0);
        check("rst_frame", 32'({palmode_o, interlaced_o, vlines_o}), 32'h0);
        rst = 1'b0;

        // First group: valid_o appears NCH+1 clocks after nVDSYNC_i low.
        send_group(4'hF, 7'h55, 7'h2A, 7'h7F);
        check("lat_pre", 32'(valid_o), 32'h0);
        nv = 1'b0; vd = 7'h0F; @(negedge clk);
        check("lat_valid", 32'(valid_o), 32'h1);
        check("sync_F", 32'(sync_o), 32'hF);
        check("pixel", 32'(pixel_o), 32'h15557F);
        check("slot1_R", 32'(pixel_o[20:14]), 32'h55);
        check("slot2_G", 32'(pixel_o[13:7]), 32'h2A);
        check("slot3_B", 32'(pixel_o[6:0]), 32'h7F);
        nv = 1'b1; vd = 7'h55; @(negedge clk);
        check("valid_pulse", 32'(valid_o), 32'h0);
        vd = 7'h2A; @(negedge clk);
        vd = 7'h7F; @(negedge clk);

        repeat (14) send_group(4'hC, 7'h01, 7'h02, 7'h03);
        check("lock_15", 32'(lock_o), 32'h0);
        send_group(4'hC, 7'h01, 7'h02, 7'h03);
        check("lock_16", 32'(lock_o), 32'h1);

        send_group(4'hC, 7'h12, 7'h34, 7'h56);
        send_group(4'hC, 7'h00, 7'h00, 7'h00);
        check("pixel2", 32'(last_pix), 32'({7'h12, 7'h34, 7'h56}));
        check("sync_C", 32'(last_sync), 32'hC);

        // Frame tracking: 263, 263, 313, 312 lines.
        frame(263);
        frame(263);
        check("ntsc_vlines", 32'(vlines_o), 32'd263);
        check("ntsc_pal", 32'(palmode_o), 32'h0);
        frame(313);
        check("ntsc_intl", 32'(interlaced_o), 32'h0);
        frame(312);
        check("pal_vlines", 32'(vlines_o), 32'd313);
        check("pal_pal", 32'(palmode_o), 32'h1);
        send_group(4'hC, 7'h01, 7'h02, 7'h03);
        send_group(4'h4, 7'h01, 7'h02, 7'h03);
        send_group(4'h4, 7'h01, 7'h02, 7'h03);
        check("pal312_vlines", 32'(vlines_o), 32'd312);
        check("pal_intl", 32'(interlaced_o), 32'h1);

        // VS and HS falling together: counter restarts at 0.
        send_group(4'hC, 7'h01, 7'h02, 7'h03);
        send_group(4'h0, 7'h01, 7'h02, 7'h03);
        repeat (5) begin
            send_group(4'h4, 7'h01, 7'h02, 7'h03);
            send_group(4'h0, 7'h01, 7'h02, 7'h03);
        end
        send_group(4'hC, 7'h01, 7'h02, 7'h03);
        send_group(4'h4, 7'h01, 7'h02, 7'h03);
        send_group(4'h4, 7'h01, 7'h02, 7'h03);
        check("vshs_vlines", 32'(vlines_o), 32'd5);
        check("vshs_pal", 32'(palmode_o), 32'h0);

        // Early nVDSYNC_i at ph=1.
        check("pre_abort_lock", 32'(lock_o), 32'h1);
        vsnap = vcnt;
        nv = 1'b0; vd = 7'h0C; @(negedge clk);
        nv = 1'b1; vd = 7'h11; @(negedge clk);
        nv = 1'b0; vd = 7'h0C; @(negedge clk);
        check("abort_lock", 32'(lock_o), 32'h0);
        nv = 1'b1; vd = 7'h01; @(negedge clk);
        vd = 7'h02; @(negedge clk);
        vd = 7'h03; @(negedge clk);
        send_group(4'hC, 7'h01, 7'h02, 7'h03);
        check("abort_valids", 32'(vcnt - vsnap), 32'd2);
        repeat (14) send_group(4'hC, 7'h01, 7'h02, 7'h03);
        check("relock_15", 32'(lock_o), 32'h0);
        send_group(4'hC, 7'h01, 7'h02, 7'h03);
        check("relock_16", 32'(lock_o), 32'h1);
        check("hold_vlines", 32'(vlines_o), 32'd5);

        // Late nVDSYNC_i: one extra clock with ph saturated.
        @(negedge clk);
        check("late_lock", 32'(lock_o), 32'h0);
        repeat (16) send_group(4'hC, 7'h01, 7'h02, 7'h03);
        check("late_relock", 32'(lock_o), 32'h1);

        // Asynchronous reset mid-frame.
        #2 rst = 1'b1;
        #1;
        check("arst_lock", 32'(lock_o), 32'h0);
        check("arst_vlines", 32'(vlines_o), 32'h0);
        check("arst_out", 32'({valid_o, sync_o, pixel_o, palmode_o, interlaced_o}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        vsnap = vcnt;
        send_group(4'hF, 7'h21, 7'h43, 7'h65);
        check("post_rst_none", 32'(vcnt - vsnap), 32'd0);
        send_group(4'hC, 7'h01, 7'h02, 7'h03);
        check("post_rst_first", 32'(vcnt - vsnap), 32'd1);
        check("post_rst_pix", 32'(last_pix), 32'({7'h21, 7'h43, 7'h65}));
        repeat (14) send_group(4'hC, 7'h01, 7'h02, 7'h03);
        check("post_rst_l15", 32'(lock_o), 32'h0);
        send_group(4'hC, 7'h01, 7'h02, 7'h03);
        check("post_rst_l16", 32'(lock_o), 32'h1);

`ifdef N64_VDEMUX_HCNT_EN
        repeat (2) begin
            send_group(4'h8, 7'h01, 7'h02, 7'h03);
            repeat (779) send_group(4'hC, 7'h01, 7'h02, 7'h03);
        end
        send_group(4'h8, 7'h01, 7'h02, 7'h03);
        send_group(4'hC, 7'h01, 7'h02, 7'h03);
        check("hpixels", 32'(hpixels_o), 32'd780);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
